lifo_burst_reader: RTL and testbench

- Downstream consumer stage for the lifo block: pops a programmed burst of entries from the lifo read port.
- Presents the popped entries on a valid/ready output stream.
- Hides the lifo's 1-cycle read latency (non-FWFT mode) behind a 2-entry output skid buffer.
- Aborts cleanly with an underrun flag if the lifo stays empty too long mid-burst.

---
 rtl/lifo_burst_reader.sv | 245 ++++++++++++++++++++++++
 tb/tb_lifo_burst_reader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_burst_reader.sv
// -----------------------------------------------------------------------------
// lifo_burst_reader
//
// Consumer stage for the lifo block. After a start pulse it pops a burst of
// up to MAX_BURST entries from the lifo read port and presents them, in pop
// order (newest first), on a valid/ready output stream. A 2-entry skid buffer
// absorbs the lifo read latency so that a continuously ready consumer sees one
// transfer per cycle. If the lifo stays empty for TIMEOUT consecutive cycles
// mid-burst, the burst is aborted and the sticky underrun flag is raised.
//
// Optional build macro: LIFO_BURST_READER_FWFT_EN
//   defined   : lifo built in FWFT mode, r_data valid in the same cycle as
//               r_req and captured on that edge (1-cycle initial latency).
//   undefined : r_data valid the cycle after r_req (2-cycle initial latency).
//
// Ports:
//   clk200     in   system clock, rising edge
//   nrst       in   synchronous active-low reset
//   start      in   one-cycle pulse, latches burst_len (ignored while busy)
//   burst_len  in   entries to pop, clamped to MAX_BURST
//   r_req      out  lifo pop request (combinational from empty/out_ready)
//   r_data     in   lifo read data
//   empty      in   lifo empty flag
//   out_data   out  stream data (skid buffer head)
//   out_valid  out  stream valid
//   out_ready  in   stream ready
//   busy       out  burst in progress
//   done       out  one-cycle pulse at burst end
//   underrun   out  sticky timeout-abort flag
// -----------------------------------------------------------------------------
module lifo_burst_reader #(
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic              clk200,
  input  logic              nrst,
  input  logic              start,
  input  logic [CNT_W-1:0]  burst_len,
  output logic              r_req,
  input  logic [DATA_W-1:0] r_data,
  input  logic              empty,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  localparam int               TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_BURST);
  localparam logic [TMO_W-1:0] TMO_END = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_delivered;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_underrun;
  logic [DATA_W-1:0] r_buf0;
  logic [DATA_W-1:0] r_buf1;
  logic [1:0]        r_occ;

  logic              w_req;
  logic              w_start_acc;
  logic              w_tmo_hit;
  logic              w_pop;
  logic              w_push;
  logic              w_inflight;
  logic [2:0]        w_level;
  logic              w_room;
  logic [CNT_W-1:0]  w_len_clamped;

  // ---------------------------------------------------------------------------
  // Read-latency handling
  // ---------------------------------------------------------------------------
`ifdef LIFO_BURST_READER_FWFT_EN
  // Data arrives with the request, so nothing is ever outstanding.
  assign w_inflight = 1'b0;
  assign w_push     = w_req;
`else
  logic r_inflight;

  always_ff @(posedge clk200) begin
    if (!nrst) begin
      // Clearing this drops any read returning after a mid-burst reset.
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
    end
  end

  assign w_inflight = r_inflight;
  assign w_push     = r_inflight;
`endif

  assign w_pop = (r_occ != 2'd0) && out_ready;

  // Occupancy the skid buffer will have once the outstanding read lands and
  // this cycle's transfer leaves; a new request is allowed only if that
  // leaves a free slot for its data.
  assign w_level = {1'b0, r_occ} + {2'b00, w_inflight} - {2'b00, w_pop};
  assign w_room  = (w_level < 3'd2);

  assign w_len_clamped = (burst_len > MAX_LEN) ? MAX_LEN : burst_len;

  // ---------------------------------------------------------------------------
  // Control FSM: next state and pop request
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_start_acc = 1'b0;
    w_tmo_hit   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = (w_len_clamped == '0) ? S_DONE : S_RUN;
        end
      end

      S_RUN: begin
        w_req = (r_issued < r_len) && !empty && w_room;
        if (r_issued == r_len) begin
          w_state_nxt = S_FLUSH;
        end else if (empty && (r_tmo == TMO_END)) begin
          // This empty cycle is the TIMEOUT-th in a row.
          w_tmo_hit   = 1'b1;
          w_state_nxt = S_FLUSH;
        end
      end

      S_FLUSH: begin
        if (!w_inflight && (r_occ == 2'd0)) begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, burst counters and underrun flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk200) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_issued    <= '0;
      r_delivered <= '0;
      r_tmo       <= '0;
      r_underrun  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_acc) begin
        r_len       <= w_len_clamped;
        r_issued    <= '0;
        r_delivered <= '0;
        r_tmo       <= '0;
        r_underrun  <= 1'b0;
      end else begin
        if (w_req) begin
          r_issued <= r_issued + CNT_W'(1);
          r_tmo    <= '0;
        end else if ((r_state == S_RUN) && empty && (r_issued < r_len)) begin
          r_tmo <= r_tmo + TMO_W'(1);
        end
        if (w_pop) begin
          r_delivered <= r_delivered + CNT_W'(1);
        end
        if (w_tmo_hit) begin
          r_underrun <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry skid buffer, FIFO ordered, r_buf0 is the head
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk200) begin
    if (!nrst) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
      r_occ  <= 2'd0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_buf0 <= r_data;
          end else begin
            r_buf1 <= r_data;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          // Pop implies at least one entry; occupancy is unchanged.
          if (r_occ == 2'd1) begin
            r_buf0 <= r_data;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= r_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign r_req     = w_req;
  assign out_valid = (r_occ != 2'd0);
  assign out_data  = r_buf0;
  assign busy      = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign done      = (r_state == S_DONE);
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_lifo_burst_reader.sv
`timescale 1ns/1ps
module tb_lifo_burst_reader;

  localparam int DATA_W    = 16;
  localparam int MAX_BURST = 8;
  localparam int TIMEOUT   = 16;
  localparam int CNT_W     = 4;

`ifdef LIFO_BURST_READER_FWFT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic              clk200 = 1'b0;
  logic              nrst;
  logic              start;
  logic [CNT_W-1:0]  burst_len;
  logic              r_req;
  logic [DATA_W-1:0] r_data;
  logic              empty;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              underrun;

  always #5 clk200 = ~clk200;

  lifo_burst_reader #(
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk200    (clk200),
    .nrst      (nrst),
    .start     (start),
    .burst_len (burst_len),
    .r_req     (r_req),
    .r_data    (r_data),
    .empty     (empty),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  // ---------------- lifo model ----------------
  logic [DATA_W-1:0] mem [16];
  int                lcnt = 0;
  logic              push_en;
  logic [DATA_W-1:0] push_data;
  logic              clr;
`ifndef LIFO_BURST_READER_FWFT_EN
  logic [DATA_W-1:0] rdata_q = '0;
`endif

  always @(posedge clk200) begin
    if (clr) begin
      lcnt <= 0;
    end else if (push_en) begin
      mem[lcnt] <= push_data;
      lcnt      <= lcnt + 1;
    end else if (r_req && lcnt != 0) begin
      lcnt <= lcnt - 1;
`ifndef LIFO_BURST_READER_FWFT_EN
      rdata_q <= mem[lcnt-1];
`endif
    end
  end

  assign empty = (lcnt == 0);
`ifdef LIFO_BURST_READER_FWFT_EN
  assign r_data = (lcnt != 0) ? mem[lcnt-1] : '0;
`else
  assign r_data = rdata_q;
`endif

  // ---------------- monitor ----------------
  int                cyc = 0;
  logic [DATA_W-1:0] got_q[$];
  int                got_cyc[$];
  int                done_cnt = 0;
  int                done_cyc = 0;
  int                req_cnt = 0;
  int                bad_pop = 0;
  int                ovf = 0;
  int                vmis = 0;
  int                occ_m = 0;
  bit                req_d = 0;

  always @(posedge clk200) cyc <= cyc + 1;

  always @(negedge clk200) begin
    int push;
    int pop;
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (r_req) req_cnt++;
    if (r_req && empty) bad_pop++;
    if (out_valid != (occ_m != 0)) vmis++;
    if (!nrst) begin
      occ_m = 0;
      req_d = 0;
    end else begin
`ifdef LIFO_BURST_READER_FWFT_EN
      push = r_req ? 1 : 0;
`else
      push = req_d ? 1 : 0;
`endif
      pop = (out_valid && out_ready) ? 1 : 0;
      occ_m = occ_m + push - pop;
      if (occ_m > 2) ovf++;
      req_d = r_req;
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int start_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] getq(input int idx);
    return (idx < got_q.size()) ? {16'h0, got_q[idx]} : 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk200);
    #1;
  endtask

  task automatic lpush(input logic [DATA_W-1:0] d);
    push_en   = 1'b1;
    push_data = d;
    tick();
    push_en   = 1'b0;
  endtask

  task automatic lclear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] len);
    start_cyc = cyc;
    start     = 1'b1;
    burst_len = len;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    int d0;
    bit seen;
    d0   = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk200);
      #1;
      if (done_cnt != d0) seen = 1'b1;
      else begin
        @(posedge clk200);
        #1;
        if (toggle) out_ready = ~out_ready;
      end
    end
    check("done_seen", {31'h0, seen}, 32'd1);
  endtask

  initial begin
    int b;
    int d0;
    int r0;
    logic [DATA_W-1:0] e3 [3];

    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int d0;
    int r0;
    logic [DATA_W-1:0] e3 [3];

    nrst = 1'b0; start = 1'b0; burst_len = '0; out_ready = 1'b1;
    push_en = 1'b0; push_data = '0; clr = 1'b0;
    repeat (3) tick();
    check("rst_r_req", r_req, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_underrun", underrun, 0);
    nrst = 1'b1;
    tick();

    // S1: three entries, ready held high
    lpush(16'h1111); lpush(16'h2222); lpush(16'h3333);
    b = got_q.size(); d0 = done_cnt;
    do_start(3);
    check("s1_busy", busy, 1);
    wait_done(40, 0);
    e3 = '{16'h3333, 16'h2222, 16'h1111};
    check("s1_count", got_q.size() - b, 3);
    for (int i = 0; i < 3; i++) check($sformatf("s1_data%0d", i), getq(b + i), e3[i]);
    check("s1_first_lat", (b < got_cyc.size()) ? got_cyc[b] - start_cyc : -1, LAT);
    check("s1_back_to_back", (b + 2 < got_cyc.size()) ? got_cyc[b+2] - got_cyc[b] : -1, 2);
    check("s1_done_cyc", done_cyc - start_cyc, LAT + 4);
    check("s1_underrun", underrun, 0);
    check("s1_lcnt", lcnt, 0);
    tick(); tick();
    check("s1_done_once", done_cnt - d0, 1);

    // S2: full lifo, toggling ready
    lclear();
    for (int i = 1; i <= 8; i++) lpush(16'h0200 + 16'(i));
    b = got_q.size(); d0 = done_cnt;
    do_start(8);
    wait_done(80, 1);
    out_ready = 1'b1;
    check("s2_count", got_q.size() - b, 8);
    for (int i = 0; i < 8; i++) check($sformatf("s2_data%0d", i), getq(b + i), 32'h0208 - 32'(i));
    check("s2_lcnt", lcnt, 0);
    check("s2_underrun", underrun, 0);
    tick(); tick();
    check("s2_done_once", done_cnt - d0, 1);

    // S3: underrun after TIMEOUT empty cycles
    lpush(16'h0301); lpush(16'h0302);
    b = got_q.size(); d0 = done_cnt;
    do_start(5);
    wait_done(60, 0);
    check("s3_count", got_q.size() - b, 2);
    check("s3_data0", getq(b), 32'h0302);
    check("s3_data1", getq(b + 1), 32'h0301);
    check("s3_done_cyc", done_cyc - start_cyc, 20);
    check("s3_underrun", underrun, 1);
    tick(); tick();
    check("s3_underrun_sticky", underrun, 1);
    check("s3_done_once", done_cnt - d0, 1);

    // S4: zero-length burst with data available
    lpush(16'h0401); lpush(16'h0402);
    r0 = req_cnt;
    do_start(0);
    check("s4_underrun_clr", underrun, 0);
    wait_done(10, 0);
    check("s4_done_cyc", done_cyc - start_cyc, 1);
    tick();
    check("s4_no_req", req_cnt - r0, 0);
    check("s4_lcnt", lcnt, 2);

    // S5: clamp 12 -> 8, start during busy ignored
    for (int i = 1; i <= 8; i++) lpush(16'h0500 + 16'(i));
    b = got_q.size(); d0 = done_cnt;
    do_start(12);
    repeat (3) tick();
    start = 1'b1; burst_len = 4'd2;
    tick();
    start = 1'b0;
    wait_done(80, 0);
    check("s5_count", got_q.size() - b, 8);
    for (int i = 0; i < 8; i++) check($sformatf("s5_data%0d", i), getq(b + i), 32'h0508 - 32'(i));
    check("s5_lcnt", lcnt, 2);
    tick(); tick();
    check("s5_done_once", done_cnt - d0, 1);

    // S6: reset mid-burst then resume
    lclear();
    for (int i = 1; i <= 6; i++) lpush(16'h00A0 + 16'(i));
    do_start(6);
    tick(); tick();
    nrst = 1'b0;
    tick();
    check("s6_r_req", r_req, 0);
    check("s6_valid", out_valid, 0);
    check("s6_data", out_data, 0);
    check("s6_busy", busy, 0);
    check("s6_done", done, 0);
    check("s6_underrun", underrun, 0);
    check("s6_lcnt", lcnt, 3);
    nrst = 1'b1;
    tick();
    b = got_q.size();
    do_start(3);
    wait_done(40, 0);
    e3 = '{16'h00A3, 16'h00A2, 16'h00A1};
    check("s6_count", got_q.size() - b, 3);
    for (int i = 0; i < 3; i++) check($sformatf("s6_data%0d", i), getq(b + i), e3[i]);
    check("s6_lcnt_end", lcnt, 0);
    tick();

    check("never_pop_empty", bad_pop, 0);
    check("skid_overflow", ovf, 0);
    check("valid_vs_occupancy", vmis, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
